// File: rtl/alarm_pkg.sv
// Shared types for the alarm trigger: state encoding, time constants and the
// snooze-target time adder.
package alarm_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    RINGING = 2'd2,
    SNOOZE  = 2'd3
  } state_e;

  localparam int HOURS_PER_DAY = 24;
  localparam int MIN_PER_HOUR  = 60;

  typedef struct packed {
    logic [5:0] hour;
    logic [5:0] mins;
  } hm_t;

  // Add minutes to hh:mm; a minute overflow carries into the hour, 23 wraps to 0.
  function automatic hm_t add_minutes(input logic [5:0] hr, input logic [5:0] mn,
                                      input logic [5:0] add);
    logic [6:0] m_sum;
    hm_t        res;
    m_sum    = {1'b0, mn} + {1'b0, add};
    res.hour = hr;
    if (m_sum >= 7'(MIN_PER_HOUR)) begin
      m_sum    = m_sum - 7'(MIN_PER_HOUR);
      res.hour = (hr == 6'(HOURS_PER_DAY - 1)) ? 6'd0 : hr + 6'd1;
    end
    res.mins = m_sum[5:0];
    return res;
  endfunction

endpackage

// File: rtl/alarm_trigger_tone_gen.sv
// Buzzer square wave: toggles every TONE_DIV enabled cycles, held at 0 when disabled.
module tone_gen #(
  parameter int TONE_DIV = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic buzzer
);

  localparam int CW = (TONE_DIV > 2) ? $clog2(TONE_DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          buz_q, buz_d;

  always_comb begin
    cnt_d = '0;
    buz_d = 1'b0;
    if (enable) begin
      if (cnt_q == CW'(TONE_DIV - 1)) begin
        cnt_d = '0;
        buz_d = ~buz_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
        buz_d = buz_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
      buz_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      buz_q <= buz_d;
    end
  end

  assign buzzer = buz_q;

endmodule

// File: rtl/alarm_trigger.sv
// Alarm ring decision: arms on enable, rings at the loaded time, handles bounded
// snooze, stop and unattended-ring timeout, and drives the buzzer.
module alarm_trigger
  import alarm_pkg::*;
#(
  parameter int SNOOZE_MIN     = 5,
  parameter int RING_TIMEOUT_S = 60,
  parameter int MAX_SNOOZE     = 3,
  parameter int TONE_DIV       = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_1hz,
  input  logic [5:0] cur_hour,
  input  logic [5:0] cur_min,
  input  logic [5:0] cur_sec,
  input  logic [5:0] alarm_hour,
  input  logic [5:0] alarm_min,
  input  logic       alarm_enable,
  input  logic       snooze,
  input  logic       stop,
  output logic       ringing,
  output logic       snoozing,
  output logic       buzzer,
  output logic [1:0] snooze_cnt
);

  localparam logic [1:0] MAX_C     = 2'(MAX_SNOOZE);
  localparam logic [7:0] TOUT_LAST = 8'(RING_TIMEOUT_S - 1);
  localparam logic [5:0] SNZ_ADD   = 6'(SNOOZE_MIN);

  state_e     state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic [7:0] tout_q, tout_d;
  hm_t        tgt_q, tgt_d;
  logic       ringing_q, ringing_d;
  logic       snoozing_q, snoozing_d;

  hm_t  snz_tgt;
  logic alarm_hit, snooze_hit;

  assign snz_tgt = add_minutes(cur_hour, cur_min, SNZ_ADD);

  // Matching only on the second-0 tick keeps a stopped alarm from re-ringing
  // in the rest of its minute.
  assign alarm_hit  = tick_1hz && (cur_hour == alarm_hour) && (cur_min == alarm_min) &&
                      (cur_sec == 6'd0);
  assign snooze_hit = tick_1hz && (cur_hour == tgt_q.hour) && (cur_min == tgt_q.mins) &&
                      (cur_sec == 6'd0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tout_d  = tout_q;
    tgt_d   = tgt_q;
    if (!alarm_enable) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE:  state_d = ARMED;
        ARMED: begin
          if (alarm_hit) begin
            state_d = RINGING;
            tout_d  = '0;
          end
        end
        RINGING: begin
          if (stop) begin
            state_d = ARMED;
            cnt_d   = '0;
          end else if (snooze && (cnt_q < MAX_C)) begin
            state_d = SNOOZE;
            tgt_d   = snz_tgt;
            cnt_d   = cnt_q + 2'd1;
          end else if (tick_1hz) begin
            if (tout_q == TOUT_LAST) begin
              state_d = ARMED;
              cnt_d   = '0;
            end else begin
              tout_d = tout_q + 8'd1;
            end
          end
        end
        SNOOZE: begin
          if (stop) begin
            state_d = ARMED;
            cnt_d   = '0;
          end else if (snooze_hit) begin
            state_d = RINGING;
            tout_d  = '0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign ringing_d  = (state_d == RINGING);
  assign snoozing_d = (state_d == SNOOZE);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      tout_q     <= '0;
      tgt_q      <= '0;
      ringing_q  <= 1'b0;
      snoozing_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      tout_q     <= tout_d;
      tgt_q      <= tgt_d;
      ringing_q  <= ringing_d;
      snoozing_q <= snoozing_d;
    end
  end

  // Enabled from the next state so the buzzer drops on the same edge as ringing.
  tone_gen #(.TONE_DIV(TONE_DIV)) u_tone (
    .clk    (clk),
    .reset  (reset),
    .enable (ringing_d),
    .buzzer (buzzer)
  );

  assign ringing    = ringing_q;
  assign snoozing   = snoozing_q;
  assign snooze_cnt = cnt_q;

endmodule

// File: tb/tb_alarm_trigger.sv
// Self-checking bench for alarm_trigger against a time-of-day (seconds) model.
module tb_alarm_trigger;

  localparam int SNOOZE_MIN     = 5;
  localparam int RING_TIMEOUT_S = 60;
  localparam int MAX_SNOOZE     = 3;
  localparam int TONE_DIV       = 4;

  logic       clk = 1'b0, reset = 1'b0, tick_1hz = 1'b0;
  logic       alarm_enable = 1'b0, snooze = 1'b0, stop = 1'b0;
  logic [5:0] cur_hour = '0, cur_min = '0, cur_sec = '0;
  logic [5:0] alarm_hour = '0, alarm_min = '0;
  logic       ringing, snoozing, buzzer;
  logic [1:0] snooze_cnt;
  logic [4:0] obs;

  int checks = 0, failures = 0;
  int tod = 0;                     // time of day in seconds
  int m_mode = 0;                  // 0 off, 1 armed, 2 ringing, 3 snoozing
  int m_cnt = 0, m_tout = 0, m_target = 0, m_age = 0;

  always #5 clk = ~clk;

  alarm_trigger #(
    .SNOOZE_MIN(SNOOZE_MIN), .RING_TIMEOUT_S(RING_TIMEOUT_S),
    .MAX_SNOOZE(MAX_SNOOZE), .TONE_DIV(TONE_DIV)
  ) dut (
    .clk(clk), .reset(reset), .tick_1hz(tick_1hz),
    .cur_hour(cur_hour), .cur_min(cur_min), .cur_sec(cur_sec),
    .alarm_hour(alarm_hour), .alarm_min(alarm_min), .alarm_enable(alarm_enable),
    .snooze(snooze), .stop(stop),
    .ringing(ringing), .snoozing(snoozing), .buzzer(buzzer), .snooze_cnt(snooze_cnt)
  );

  assign obs = {ringing, snoozing, snooze_cnt, buzzer};

  function automatic logic [4:0] expv();
    logic bz;
    bz = (m_mode == 2) ? 1'(((m_age + 1) / TONE_DIV) % 2) : 1'b0;
    return {m_mode == 2, m_mode == 3, 2'(m_cnt), bz};
  endfunction

  // Present one cycle of inputs, advance the model, then land 1 time unit after the edge.
  task automatic step(input logic tk, input logic sz, input logic sp);
    int prev;
    prev     = m_mode;
    cur_hour = 6'(tod / 3600);
    cur_min  = 6'((tod / 60) % 60);
    cur_sec  = 6'(tod % 60);
    tick_1hz = tk; snooze = sz; stop = sp;
    if (!reset) begin
      m_mode = 0; m_cnt = 0; m_tout = 0;
    end else if (!alarm_enable) begin
      m_mode = 0; m_cnt = 0;
    end else begin
      case (m_mode)
        0: m_mode = 1;
        1: if (tk && tod % 60 == 0 &&
               tod / 60 == int'(alarm_hour) * 60 + int'(alarm_min)) begin
             m_mode = 2; m_tout = 0;
           end
        2: if (sp) begin
             m_mode = 1; m_cnt = 0;
           end else if (sz && m_cnt < MAX_SNOOZE) begin
             m_mode = 3; m_cnt++; m_target = (tod / 60 + SNOOZE_MIN) % 1440;
           end else if (tk) begin
             m_tout++;
             if (m_tout == RING_TIMEOUT_S) begin m_mode = 1; m_cnt = 0; end
           end
        default: if (sp) begin
             m_mode = 1; m_cnt = 0;
           end else if (tk && tod % 60 == 0 && tod / 60 == m_target) begin
             m_mode = 2; m_tout = 0;
           end
      endcase
    end
    m_age = (reset && m_mode == 2 && prev == 2) ? m_age + 1 : 0;
    @(posedge clk);
    #1;
    tick_1hz = 1'b0; snooze = 1'b0; stop = 1'b0;
  endtask

  // Advance n seconds, with a random idle gap before each tick.
  task automatic adv(input int n);
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 2)) step(1'b0, 1'b0, 1'b0);
      tod = (tod + 1) % 86400;
      step(1'b1, 1'b0, 1'b0);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; alarm_enable = 1'b0;
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    checks++;
    if (obs !== 5'b0) begin
      failures++; $display("FAIL reset_state got=%b exp=%b", obs, 5'b0);
    end
    reset = 1'b1; alarm_enable = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    checks++;
    if (obs !== expv()) begin
      failures++; $display("FAIL arm_after_reset got=%b exp=%b", obs, expv());
    end
  endtask

  task automatic test_ring_tone();
    int rise0, rise1, nrise;
    logic prev_bz;
    alarm_hour = 6'd7; alarm_min = 6'd30;
    tod = 7 * 3600 + 29 * 60 + 50;
    for (int i = 0; i < 9; i++) begin
      adv(1);
      checks++;
      if (obs !== expv() || ringing !== 1'b0) begin
        failures++; $display("FAIL pre_alarm tod=%0d got=%b exp=%b", tod, obs, expv());
      end
    end
    adv(1);
    checks++;
    if (ringing !== 1'b1 || obs !== expv()) begin
      failures++; $display("FAIL ring_at_0730 got=%b exp=%b", obs, expv());
    end
    nrise = 0; rise0 = 0; rise1 = 0; prev_bz = buzzer;
    for (int c = 0; c < 6 * TONE_DIV; c++) begin
      step(1'b0, 1'b0, 1'b0);
      checks++;
      if (obs !== expv()) begin
        failures++; $display("FAIL tone_seq c=%0d got=%b exp=%b", c, obs, expv());
      end
      if (buzzer === 1'b1 && prev_bz === 1'b0) begin
        if (nrise == 0) rise0 = c; else if (nrise == 1) rise1 = c;
        nrise++;
      end
      prev_bz = buzzer;
    end
    checks++;
    if (nrise < 2 || rise1 - rise0 != 2 * TONE_DIV) begin
      failures++;
      $display("FAIL tone_period rises=%0d period=%0d exp=%0d", nrise, rise1 - rise0, 2 * TONE_DIV);
    end
  endtask

  task automatic test_stop_no_retrigger();
    step(1'b0, 1'b0, 1'b1);
    checks++;
    if (obs !== 5'b0 || obs !== expv()) begin
      failures++; $display("FAIL stop_ring got=%b exp=%b", obs, expv());
    end
    for (int i = 0; i < 59; i++) begin
      adv(1);
      checks++;
      if (ringing !== 1'b0 || obs !== expv()) begin
        failures++; $display("FAIL no_retrigger tod=%0d got=%b exp=%b", tod, obs, expv());
      end
    end
  endtask

  task automatic test_snooze_wrap();
    alarm_hour = 6'd23; alarm_min = 6'd57;
    tod = 23 * 3600 + 56 * 60 + 58;
    adv(2);
    adv(10);
    checks++;
    if (ringing !== 1'b1 || obs !== expv()) begin
      failures++; $display("FAIL ring_2357 got=%b exp=%b", obs, expv());
    end
    step(1'b0, 1'b1, 1'b0);
    checks++;
    if (snoozing !== 1'b1 || snooze_cnt !== 2'd1 || obs !== expv()) begin
      failures++; $display("FAIL snooze_first got=%b exp=%b", obs, expv());
    end
    // A new alarm time loaded mid-snooze must not move the latched target.
    alarm_hour = 6'd0; alarm_min = 6'd1;
    for (int i = 0; i < 289; i++) begin
      adv(1);
      checks++;
      if (ringing !== 1'b0 || obs !== expv()) begin
        failures++; $display("FAIL snooze_wait tod=%0d got=%b exp=%b", tod, obs, expv());
      end
    end
    adv(1);
    checks++;
    if (ringing !== 1'b1 || tod != 120 || obs !== expv()) begin
      failures++; $display("FAIL rering_0002 tod=%0d got=%b exp=%b", tod, obs, expv());
    end
  endtask

  task automatic test_max_snooze();
    for (int k = 2; k <= MAX_SNOOZE; k++) begin
      step(1'b0, 1'b1, 1'b0);
      checks++;
      if (snoozing !== 1'b1 || snooze_cnt !== 2'(k) || obs !== expv()) begin
        failures++; $display("FAIL snooze_k%0d got=%b exp=%b", k, obs, expv());
      end
      adv(299);
      checks++;
      if (ringing !== 1'b0 || obs !== expv()) begin
        failures++; $display("FAIL snooze_early k=%0d got=%b exp=%b", k, obs, expv());
      end
      adv(1);
      checks++;
      if (ringing !== 1'b1 || obs !== expv()) begin
        failures++; $display("FAIL snooze_rering k=%0d got=%b exp=%b", k, obs, expv());
      end
    end
    step(1'b0, 1'b1, 1'b0);
    checks++;
    if (ringing !== 1'b1 || snoozing !== 1'b0 || snooze_cnt !== 2'd3 || obs !== expv()) begin
      failures++; $display("FAIL snooze_over_max got=%b exp=%b", obs, expv());
    end
  endtask

  task automatic test_timeout();
    for (int i = 0; i < RING_TIMEOUT_S - 1; i++) begin
      adv(1);
      checks++;
      if (ringing !== 1'b1 || obs !== expv()) begin
        failures++; $display("FAIL timeout_early i=%0d got=%b exp=%b", i, obs, expv());
      end
    end
    adv(1);
    checks++;
    if (obs !== 5'b0 || obs !== expv()) begin
      failures++; $display("FAIL timeout_stop got=%b exp=%b", obs, expv());
    end
  endtask

  task automatic test_stop_and_snooze();
    alarm_hour = 6'd5; alarm_min = 6'd0;
    tod = 4 * 3600 + 59 * 60 + 59;
    adv(1);
    checks++;
    if (ringing !== 1'b1) begin
      failures++; $display("FAIL ring_0500 got=%b exp=1", ringing);
    end
    step(1'b0, 1'b1, 1'b1);
    checks++;
    if (obs !== 5'b0 || obs !== expv()) begin
      failures++; $display("FAIL stop_beats_snooze got=%b exp=%b", obs, expv());
    end
  endtask

  task automatic test_disable_in_snooze();
    alarm_hour = 6'd6; alarm_min = 6'd0;
    tod = 5 * 3600 + 59 * 60 + 59;
    adv(1);
    step(1'b0, 1'b1, 1'b0);
    checks++;
    if (snoozing !== 1'b1 || obs !== expv()) begin
      failures++; $display("FAIL snooze_0600 got=%b exp=%b", obs, expv());
    end
    alarm_enable = 1'b0;
    step(1'b0, 1'b0, 1'b0);
    checks++;
    if (obs !== 5'b0 || obs !== expv()) begin
      failures++; $display("FAIL disable_snooze got=%b exp=%b", obs, expv());
    end
    tod = 6 * 3600 + 4 * 60 + 59;
    adv(1);
    checks++;
    if (ringing !== 1'b0 || obs !== expv()) begin
      failures++; $display("FAIL no_ring_disabled got=%b exp=%b", obs, expv());
    end
    alarm_enable = 1'b1;
    step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid_ring();
    alarm_hour = 6'd7; alarm_min = 6'd0;
    tod = 6 * 3600 + 59 * 60 + 59;
    adv(1);
    repeat (TONE_DIV) step(1'b0, 1'b0, 1'b0);
    checks++;
    if (ringing !== 1'b1 || buzzer !== 1'b1 || obs !== expv()) begin
      failures++; $display("FAIL buzz_before_reset got=%b exp=%b", obs, expv());
    end
    reset = 1'b0;
    step(1'b0, 1'b0, 1'b0);
    checks++;
    if (obs !== 5'b0 || obs !== expv()) begin
      failures++; $display("FAIL reset_mid_ring got=%b exp=%b", obs, expv());
    end
    reset = 1'b1;
    step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    logic tk, sz, sp;
    alarm_hour = 6'($urandom_range(0, 23));
    alarm_min  = 6'($urandom_range(0, 59));
    tod = (int'(alarm_hour) * 3600 + int'(alarm_min) * 60 - 20 + 86400) % 86400;
    for (int c = 0; c < 4000; c++) begin
      tk = ($urandom_range(0, 2) == 0);
      sz = ($urandom_range(0, 24) == 0);
      sp = ($urandom_range(0, 79) == 0);
      alarm_enable = ($urandom_range(0, 299) != 0);
      if (tk) tod = (tod + 1) % 86400;
      step(tk, sz, sp);
      checks++;
      if (obs !== expv()) begin
        failures++; $display("FAIL random c=%0d tod=%0d got=%b exp=%b", c, tod, obs, expv());
      end
    end
  endtask

  initial begin
    test_reset();
    test_ring_tone();
    test_stop_no_retrigger();
    test_snooze_wrap();
    test_max_snooze();
    test_timeout();
    test_stop_and_snooze();
    test_disable_in_snooze();
    test_reset_mid_ring();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
